// File: rtl/count_timer_ctrl.sv
// count_timer_ctrl: loadable down-counter sequencer with prescaler,
// reload handshake, start/stop, one-shot/periodic mode and expiry pulse.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   load_valid/ready    reload handshake, load_value sampled on fire
//   start, stop         begin / halt counting
//   periodic            auto-reload mode, sampled at start
//   preset              force count to all ones
//   count               current count register
//   running, done       state == RUN / state == DONE
//   expire              one-cycle pulse on a tick at count 0
module count_timer_ctrl #(
  parameter int WIDTH = 16,
  parameter int DIV   = 1,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             preset,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expire,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic [DIV_W-1:0] presc;
  logic             mode;
  logic             load_fire;

  assign load_ready = (state != RUN);
  assign running    = (state == RUN);
  assign done       = (state == DONE);
  assign load_fire  = load_valid & load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      presc  <= '0;
      mode   <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (preset) begin
        count <= '1;
        presc <= '0;
        state <= IDLE;
      end else if (load_fire) begin
        reload <= load_value;
        count  <= load_value;
        state  <= IDLE;
      end else if (stop) begin
        // stop outranks start even outside RUN; it only moves RUN
        if (state == RUN) state <= IDLE;
      end else if (start && state != RUN) begin
        state <= RUN;
        presc <= '0;
        mode  <= periodic;
      end else if (state == RUN) begin
        if (presc == LAST) begin
          presc <= '0;
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            expire <= 1'b1;
            if (mode) count <= reload;
            else      state <= DONE;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_count_timer_ctrl.sv
// tb_count_timer_ctrl: vector table, corner sequences and random
// stimulus against a behavioural model, for DIV=1 and DIV=4.
module tb_count_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_valid, start, stop, periodic, preset;
  logic [15:0] load_value;
  logic        rdy1, run1, exp1, done1;
  logic        rdy4, run4, exp4, done4;
  logic [15:0] cnt1, cnt4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  count_timer_ctrl #(.WIDTH(16), .DIV(1), .DIV_W(8)) u1 (
    .clk(clk), .rst(rst), .load_valid(load_valid),
    .load_ready(rdy1), .load_value(load_value),
    .start(start), .stop(stop), .periodic(periodic),
    .preset(preset), .count(cnt1), .running(run1),
    .expire(exp1), .done(done1)
  );

  count_timer_ctrl #(.WIDTH(16), .DIV(4), .DIV_W(8)) u4 (
    .clk(clk), .rst(rst), .load_valid(load_valid),
    .load_ready(rdy4), .load_value(load_value),
    .start(start), .stop(stop), .periodic(periodic),
    .preset(preset), .count(cnt4), .running(run4),
    .expire(exp4), .done(done4)
  );

  // model: state 0 idle, 1 run, 2 done
  int m_div[2] = '{1, 4};
  int m_st[2], m_cnt[2], m_rel[2], m_pre[2], m_mode[2], m_exp[2];

  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_exp[k] = 0;
      if (rst) begin
        m_st[k] = 0; m_cnt[k] = 0; m_rel[k] = 0;
        m_pre[k] = 0; m_mode[k] = 0;
      end else if (preset) begin
        m_cnt[k] = 65535; m_pre[k] = 0; m_st[k] = 0;
      end else if (load_valid && m_st[k] != 1) begin
        m_rel[k] = load_value; m_cnt[k] = load_value; m_st[k] = 0;
      end else if (stop) begin
        if (m_st[k] == 1) m_st[k] = 0;
      end else if (start && m_st[k] != 1) begin
        m_st[k] = 1; m_pre[k] = 0; m_mode[k] = periodic;
      end else if (m_st[k] == 1) begin
        m_pre[k] = (m_pre[k] + 1) % m_div[k];
        if (m_pre[k] == 0) begin
          if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
          else begin
            m_exp[k] = 1;
            if (m_mode[k] != 0) m_cnt[k] = m_rel[k];
            else m_st[k] = 2;
          end
        end
      end
    end
  endtask

  task automatic model_chk();
    chk("m1.count", int'(cnt1), m_cnt[0]);
    chk("m1.running", int'(run1), int'(m_st[0] == 1));
    chk("m1.done", int'(done1), int'(m_st[0] == 2));
    chk("m1.ready", int'(rdy1), int'(m_st[0] != 1));
    chk("m1.expire", int'(exp1), m_exp[0]);
    chk("m4.count", int'(cnt4), m_cnt[1]);
    chk("m4.running", int'(run4), int'(m_st[1] == 1));
    chk("m4.done", int'(done4), int'(m_st[1] == 2));
    chk("m4.ready", int'(rdy4), int'(m_st[1] != 1));
    chk("m4.expire", int'(exp4), m_exp[1]);
  endtask

  task automatic step(input logic r, input logic pr,
                      input logic lv, input logic [15:0] v,
                      input logic st, input logic sp,
                      input logic pe);
    rst = r; preset = pr; load_valid = lv; load_value = v;
    start = st; stop = sp; periodic = pe;
    @(posedge clk);
    model_edge();
    #1;
    model_chk();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 16'd0, 0, 0, 0);
  endtask

  typedef struct {
    logic        r, pr, lv;
    logic [15:0] v;
    logic        st, sp, pe;
    logic [15:0] e_cnt;
    logic        e_run, e_exp, e_done, e_rdy;
  } vec_t;

  vec_t tv[27];

  initial begin
    // r pr lv val st sp pe | cnt run exp done rdy  (DIV=1)
    tv[0]  = '{1,0,0,16'd0,0,0,0, 16'd0,0,0,0,1};
    tv[1]  = '{0,0,1,16'd3,0,0,0, 16'd3,0,0,0,1};
    tv[2]  = '{0,0,0,16'd0,1,0,0, 16'd3,1,0,0,0};
    tv[3]  = '{0,0,0,16'd0,0,0,0, 16'd2,1,0,0,0};
    tv[4]  = '{0,0,0,16'd0,0,0,0, 16'd1,1,0,0,0};
    tv[5]  = '{0,0,0,16'd0,0,0,0, 16'd0,1,0,0,0};
    tv[6]  = '{0,0,0,16'd0,0,0,0, 16'd0,0,1,1,1};
    tv[7]  = '{0,0,0,16'd0,0,0,0, 16'd0,0,0,1,1};
    tv[8]  = '{0,0,1,16'd2,0,0,0, 16'd2,0,0,0,1};
    tv[9]  = '{0,0,0,16'd0,1,0,1, 16'd2,1,0,0,0};
    tv[10] = '{0,0,0,16'd0,0,0,0, 16'd1,1,0,0,0};
    tv[11] = '{0,0,0,16'd0,0,0,0, 16'd0,1,0,0,0};
    tv[12] = '{0,0,0,16'd0,0,0,0, 16'd2,1,1,0,0};
    tv[13] = '{0,0,0,16'd0,0,0,0, 16'd1,1,0,0,0};
    tv[14] = '{0,0,0,16'd0,0,0,0, 16'd0,1,0,0,0};
    tv[15] = '{0,0,0,16'd0,0,0,0, 16'd2,1,1,0,0};
    tv[16] = '{0,0,1,16'd7,0,0,0, 16'd1,1,0,0,0};
    tv[17] = '{0,0,1,16'd7,0,1,0, 16'd1,0,0,0,1};
    tv[18] = '{0,0,1,16'd7,0,0,0, 16'd7,0,0,0,1};
    tv[19] = '{0,1,1,16'd9,0,0,0, 16'hFFFF,0,0,0,1};
    tv[20] = '{0,0,0,16'd0,1,0,0, 16'hFFFF,1,0,0,0};
    tv[21] = '{0,0,0,16'd0,0,1,0, 16'hFFFF,0,0,0,1};
    tv[22] = '{0,0,1,16'd0,0,0,0, 16'd0,0,0,0,1};
    tv[23] = '{0,0,0,16'd0,1,0,0, 16'd0,1,0,0,0};
    tv[24] = '{0,0,0,16'd0,0,1,0, 16'd0,0,0,0,1};
    tv[25] = '{0,0,0,16'd0,1,0,0, 16'd0,1,0,0,0};
    tv[26] = '{0,0,0,16'd0,0,0,0, 16'd0,0,1,1,1};

    for (int i = 0; i < 27; i++) begin
      step(tv[i].r, tv[i].pr, tv[i].lv, tv[i].v,
           tv[i].st, tv[i].sp, tv[i].pe);
      chk($sformatf("v%0d.count", i), int'(cnt1), int'(tv[i].e_cnt));
      chk($sformatf("v%0d.running", i), int'(run1), int'(tv[i].e_run));
      chk($sformatf("v%0d.expire", i), int'(exp1), int'(tv[i].e_exp));
      chk($sformatf("v%0d.done", i), int'(done1), int'(tv[i].e_done));
      chk($sformatf("v%0d.ready", i), int'(rdy1), int'(tv[i].e_rdy));
    end

    // prescale on the DIV=4 instance
    step(1, 0, 0, 16'd0, 0, 0, 0);
    step(0, 0, 1, 16'd1, 0, 0, 0);
    step(0, 0, 0, 16'd0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      idle_step();
      if (i == 3) chk("pre.count_hold", int'(cnt4), 1);
      if (i == 4) chk("pre.count_dec", int'(cnt4), 0);
      if (i == 7) chk("pre.no_expire", int'(exp4), 0);
      if (i == 8) begin
        chk("pre.expire", int'(exp4), 1);
        chk("pre.done", int'(done4), 1);
      end
    end

    // reset mid-run at count 5
    step(0, 0, 1, 16'd8, 0, 0, 0);
    step(0, 0, 0, 16'd0, 1, 0, 1);
    for (int i = 0; i < 3; i++) idle_step();
    chk("rmr.count5", int'(cnt1), 5);
    step(1, 0, 0, 16'd0, 0, 0, 0);
    chk("rmr.count", int'(cnt1), 0);
    chk("rmr.running", int'(run1), 0);
    chk("rmr.expire", int'(exp1), 0);
    chk("rmr.ready", int'(rdy1), 1);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(199) == 0),
           ($urandom_range(149) == 0),
           ($urandom_range(5) == 0),
           16'($urandom_range(6)),
           ($urandom_range(4) == 0),
           ($urandom_range(11) == 0),
           1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
